// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path streaming pipeline.
// Holds the geometry parameters, the opcode and operand-select encodings,
// and the per-lane helper functions used by every column.
package data_path_pkg;

  localparam int phit_size     = 512;
  localparam int dwidth_double = 64;
  localparam int num_col       = 6;
  localparam int dwidth_RFadd  = 4;
  localparam int lanes         = 8;
  localparam int rf_depth      = 16;

  typedef enum logic [1:0] {
    ADD  = 2'b00,
    SUB  = 2'b01,
    MUL  = 2'b10,
    PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STREAM   = 2'b00,
    RF       = 2'b01,
    CONST    = 2'b10,
    FEEDBACK = 2'b11
  } mux_sel_e;

  // One lane of the column ALU; all results wrap modulo 2^64.
  function automatic logic [dwidth_double-1:0] lane_alu(
    input logic [1:0]               op,
    input logic [dwidth_double-1:0] a,
    input logic [dwidth_double-1:0] b
  );
    logic [dwidth_double-1:0] res;
    case (op_e'(op))
      ADD:     res = a + b;
      SUB:     res = a - b;
      MUL:     res = a * b;
      PASS:    res = a;
      default: res = a;
    endcase
    return res;
  endfunction

  // Operand select for one lane.
  function automatic logic [dwidth_double-1:0] lane_mux(
    input logic [1:0]               sel,
    input logic [dwidth_double-1:0] stream_lane,
    input logic [dwidth_double-1:0] rf_lane,
    input logic [dwidth_double-1:0] const_lane,
    input logic [dwidth_double-1:0] fb_lane
  );
    logic [dwidth_double-1:0] res;
    case (mux_sel_e'(sel))
      STREAM:   res = stream_lane;
      RF:       res = rf_lane;
      CONST:    res = const_lane;
      FEEDBACK: res = fb_lane;
      default:  res = stream_lane;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_path_pe_column.sv
// pe_column: one pipeline column of data_path.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   col_in              512-bit phit entering this column (8 x 64-bit lanes)
//   imm, itr, is_itr    64-bit constants broadcast to all lanes; is_itr picks itr
//   sel_mux0, sel_mux1  operand A / operand B selects
//   op                  lane opcode
//   wen, rd_addr, wr_addr  register-file controls (combinational read)
//   col_out             registered column result
module pe_column
  import data_path_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [phit_size-1:0]     col_in,
  input  logic [dwidth_double-1:0] imm,
  input  logic [dwidth_double-1:0] itr,
  input  logic                     is_itr,
  input  logic [1:0]               sel_mux0,
  input  logic [1:0]               sel_mux1,
  input  logic [1:0]               op,
  input  logic                     wen,
  input  logic [dwidth_RFadd-1:0]  rd_addr,
  input  logic [dwidth_RFadd-1:0]  wr_addr,
  output logic [phit_size-1:0]     col_out
);

  logic [phit_size-1:0]     out_r;
  logic [phit_size-1:0]     rf_r [rf_depth];
  logic [phit_size-1:0]     rf_rd_s;
  logic [phit_size-1:0]     result_s;
  logic [dwidth_double-1:0] const_s;

  // Read port sees the pre-edge contents, so a same-cycle write is not bypassed.
  assign rf_rd_s = rf_r[rd_addr];
  assign col_out = out_r;

  // Constant operand source selection.
  always_comb begin
    const_s = imm;
    if (is_itr) begin
      const_s = itr;
    end else begin
      const_s = imm;
    end
  end

  // Eight identical lane datapaths: operand muxes followed by the ALU.
  always_comb begin
    logic [dwidth_double-1:0] a_v;
    logic [dwidth_double-1:0] b_v;
    result_s = '0;
    a_v      = '0;
    b_v      = '0;
    for (int l = 0; l < lanes; l++) begin
      a_v = lane_mux(sel_mux0, col_in[l*dwidth_double +: dwidth_double],
                     rf_rd_s[l*dwidth_double +: dwidth_double], const_s,
                     out_r[l*dwidth_double +: dwidth_double]);
      b_v = lane_mux(sel_mux1, col_in[l*dwidth_double +: dwidth_double],
                     rf_rd_s[l*dwidth_double +: dwidth_double], const_s,
                     out_r[l*dwidth_double +: dwidth_double]);
      result_s[l*dwidth_double +: dwidth_double] = lane_alu(op, a_v, b_v);
    end
  end

  // Output register and register file; reset clears both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= '0;
      for (int i = 0; i < rf_depth; i++) begin
        rf_r[i] <= '0;
      end
    end else begin
      out_r <= result_s;
      if (wen) begin
        rf_r[wr_addr] <= result_s;
      end
    end
  end

endmodule

// File: rtl/data_path.sv
// data_path: six-column streaming SIMD pipeline A0 -> A1 -> B -> C0 -> C1 -> D.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   stream_in                input phit (8 x 64-bit lanes)
//   imm, itr, isItr          per-column constants and constant-source select
//   sel_mux4                 per column {mux0, mux1}, 4 bits each
//   op                       per-column opcode, 2 bits each
//   wen_RF, rd_addr_RF, wr_addr_RF  per-column register-file controls
//   stream_out_PE*           registered result of each column
//   stream_out               registered result of the last column (D)
module data_path
  import data_path_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic [phit_size-1:0]             stream_in,
  input  logic [num_col*dwidth_double-1:0] imm,
  input  logic [num_col*dwidth_double-1:0] itr,
  input  logic [num_col-1:0]               isItr,
  input  logic [num_col*4-1:0]             sel_mux4,
  input  logic [num_col*2-1:0]             op,
  input  logic [num_col-1:0]               wen_RF,
  input  logic [num_col*dwidth_RFadd-1:0]  rd_addr_RF,
  input  logic [num_col*dwidth_RFadd-1:0]  wr_addr_RF,
  output logic [phit_size-1:0]             stream_out_PEa0,
  output logic [phit_size-1:0]             stream_out_PEa1,
  output logic [phit_size-1:0]             stream_out_PEb,
  output logic [phit_size-1:0]             stream_out_PEc0,
  output logic [phit_size-1:0]             stream_out_PEc1,
  output logic [phit_size-1:0]             stream_out
);

  logic [phit_size-1:0] col_out_s [num_col];

  for (genvar c = 0; c < num_col; c++) begin : g_col
    logic [phit_size-1:0] col_in_s;

    if (c == 0) begin : g_first
      assign col_in_s = stream_in;
    end else begin : g_chain
      assign col_in_s = col_out_s[c-1];
    end

    pe_column u_pe (
      .clk      (clk),
      .rst      (rst),
      .col_in   (col_in_s),
      .imm      (imm[c*dwidth_double +: dwidth_double]),
      .itr      (itr[c*dwidth_double +: dwidth_double]),
      .is_itr   (isItr[c]),
      .sel_mux0 (sel_mux4[4*c+2 +: 2]),
      .sel_mux1 (sel_mux4[4*c +: 2]),
      .op       (op[2*c +: 2]),
      .wen      (wen_RF[c]),
      .rd_addr  (rd_addr_RF[c*dwidth_RFadd +: dwidth_RFadd]),
      .wr_addr  (wr_addr_RF[c*dwidth_RFadd +: dwidth_RFadd]),
      .col_out  (col_out_s[c])
    );
  end

  assign stream_out_PEa0 = col_out_s[0];
  assign stream_out_PEa1 = col_out_s[1];
  assign stream_out_PEb  = col_out_s[2];
  assign stream_out_PEc0 = col_out_s[3];
  assign stream_out_PEc1 = col_out_s[4];
  assign stream_out      = col_out_s[5];

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: table of column-B ALU vectors plus
// hand-written sequences for reset, chain latency, isItr, feedback and RF.
module tb_data_path;
  import data_path_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst;
  logic [phit_size-1:0]             stream_in;
  logic [num_col*dwidth_double-1:0] imm;
  logic [num_col*dwidth_double-1:0] itr;
  logic [num_col-1:0]               isItr;
  logic [num_col*4-1:0]             sel_mux4;
  logic [num_col*2-1:0]             op;
  logic [num_col-1:0]               wen_RF;
  logic [num_col*dwidth_RFadd-1:0]  rd_addr_RF;
  logic [num_col*dwidth_RFadd-1:0]  wr_addr_RF;
  logic [phit_size-1:0] out_a0, out_a1, out_b, out_c0, out_c1, out_d;

  int errors = 0;
  int checks = 0;

  data_path dut (
    .clk(clk), .rst(rst), .stream_in(stream_in), .imm(imm), .itr(itr),
    .isItr(isItr), .sel_mux4(sel_mux4), .op(op), .wen_RF(wen_RF),
    .rd_addr_RF(rd_addr_RF), .wr_addr_RF(wr_addr_RF),
    .stream_out_PEa0(out_a0), .stream_out_PEa1(out_a1), .stream_out_PEb(out_b),
    .stream_out_PEc0(out_c0), .stream_out_PEc1(out_c1), .stream_out(out_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  o;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    stream_in  = '0;
    imm        = '0;
    itr        = '0;
    isItr      = '0;
    sel_mux4   = '0;
    op         = '0;
    wen_RF     = '0;
    rd_addr_RF = '0;
    wr_addr_RF = '0;
  endtask

  task automatic set_col(input int c, input logic [1:0] m0, input logic [1:0] m1,
                         input logic [1:0] o);
    sel_mux4[4*c +: 4] = {m0, m1};
    op[2*c +: 2]       = o;
  endtask

  // Pulse reset between clock edges; released before the next rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [511:0] bcast;
    rst = 1'b1;
    clear_ctrl();
    repeat (2) tick();
    rst = 1'b0;

    // ---------------- Chain add: latency 1 per column, 6 end to end
    stream_in[63:0] = 64'd3;
    set_col(0, CONST, STREAM, ADD);
    imm[63:0] = 64'd1;
    for (int c = 1; c < num_col; c++) set_col(c, STREAM, STREAM, PASS);
    do_reset();
    tick();
    chk64("chain_a0_lane0", out_a0[63:0], 64'd4);
    for (int k = 1; k < lanes; k++) chk64($sformatf("chain_a0_lane%0d", k), out_a0[64*k +: 64], 64'd1);
    repeat (4) tick();
    chk64("chain_d_cycle5", out_d[63:0], 64'd0);
    tick();
    chk64("chain_d_cycle6", out_d[63:0], 64'd4);
    for (int k = 1; k < lanes; k++) chk64($sformatf("chain_d_lane%0d", k), out_d[64*k +: 64], 64'd1);

    // ---------------- Asynchronous reset with arbitrary inputs
    stream_in = {16{32'hA5A5_5A5A}};
    imm       = {12{32'h1234_5678}};
    #2;
    rst = 1'b1;
    #1;
    chk("rst_a0", out_a0, 512'd0);
    chk("rst_a1", out_a1, 512'd0);
    chk("rst_b",  out_b,  512'd0);
    chk("rst_c0", out_c0, 512'd0);
    chk("rst_c1", out_c1, 512'd0);
    chk("rst_d",  out_d,  512'd0);
    tick();
    chk("rst_d_held", out_d, 512'd0);
    rst = 1'b0;

    // ---------------- Table-driven column B ALU vectors (A from column 1 constant)
    vecs[0] = '{a: 64'd7, b: 64'd10, o: ADD, exp: 64'd17};
    vecs[1] = '{a: 64'd7, b: 64'd10, o: SUB, exp: 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[2] = '{a: 64'd7, b: 64'd10, o: MUL, exp: 64'd70};
    vecs[3] = '{a: 64'h8000_0000_0000_0000, b: 64'd2, o: MUL, exp: 64'd0};
    vecs[4] = '{a: 64'd7, b: 64'd10, o: PASS, exp: 64'd7};
    vecs[5] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, o: ADD, exp: 64'd0};
    vecs[6] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd10, o: MUL, exp: 64'hFFFF_FFFF_FFFF_FFF6};
    vecs[7] = '{a: 64'd5, b: 64'd10, o: SUB, exp: 64'hFFFF_FFFF_FFFF_FFFB};
    clear_ctrl();
    for (int i = 0; i < 8; i++) begin
      set_col(1, CONST, STREAM, PASS);
      imm[64*1 +: 64] = vecs[i].a;
      set_col(2, STREAM, CONST, vecs[i].o);
      imm[64*2 +: 64] = vecs[i].b;
      repeat (2) tick();
      bcast = {8{vecs[i].exp}};
      chk($sformatf("ops[%0d]", i), out_b, bcast);
    end

    // ---------------- isItr selects the constant on the next edge
    clear_ctrl();
    set_col(3, CONST, STREAM, PASS);
    imm[64*3 +: 64] = 64'd5;
    itr[64*3 +: 64] = 64'd9;
    tick();
    chk64("isitr_0", out_c0[63:0], 64'd5);
    isItr[3] = 1'b1;
    chk64("isitr_before_edge", out_c0[63:0], 64'd5);
    tick();
    chk64("isitr_1", out_c0[63:0], 64'd9);
    chk64("isitr_1_lane7", out_c0[64*7 +: 64], 64'd9);

    // ---------------- Feedback accumulate from reset
    clear_ctrl();
    set_col(1, FEEDBACK, CONST, ADD);
    imm[64*1 +: 64] = 64'd1;
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk64($sformatf("accum_%0d", n), out_a1[63:0], 64'(n));
    end

    // ---------------- Register file: write 42 at addr 3, read back later
    clear_ctrl();
    set_col(4, CONST, STREAM, PASS);
    imm[64*4 +: 64] = 64'd42;
    wen_RF[4] = 1'b1;
    wr_addr_RF[4*4 +: 4] = 4'd3;
    tick();
    chk64("rf_write_out", out_c1[63:0], 64'd42);
    wen_RF[4] = 1'b0;
    imm[64*4 +: 64] = 64'd0;
    tick();
    chk64("rf_const_zero", out_c1[63:0], 64'd0);
    set_col(4, RF, STREAM, PASS);
    rd_addr_RF[4*4 +: 4] = 4'd3;
    tick();
    chk("rf_read_3", out_c1, {8{64'd42}});

    // Same-cycle read/write of addr 5 returns the prior value.
    set_col(4, CONST, STREAM, PASS);
    imm[64*4 +: 64] = 64'd11;
    wen_RF[4] = 1'b1;
    wr_addr_RF[4*4 +: 4] = 4'd5;
    tick();
    set_col(4, RF, CONST, ADD);
    imm[64*4 +: 64] = 64'd100;
    rd_addr_RF[4*4 +: 4] = 4'd5;
    tick();
    chk64("rf_rw_same_1", out_c1[63:0], 64'd111);
    tick();
    chk64("rf_rw_same_2", out_c1[63:0], 64'd211);
    wen_RF[4] = 1'b0;
    set_col(4, RF, STREAM, PASS);
    tick();
    chk64("rf_rw_final", out_c1[63:0], 64'd211);

    // RF contents cleared by reset.
    do_reset();
    rd_addr_RF[4*4 +: 4] = 4'd3;
    tick();
    chk("rf_after_rst_3", out_c1, 512'd0);
    rd_addr_RF[4*4 +: 4] = 4'd5;
    tick();
    chk("rf_after_rst_5", out_c1, 512'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Ports SHALL be, in order:
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stream_in  in  phit_size  input phit; 8 lanes of 64 bits, lane k = bits [64k+63:64k].
- imm  in  num_col*64  per-column immediate; column c = bits [64c+63:64c].
- itr  in  num_col*64  per-column iteration constant, same slicing as imm.
- isItr  in  num_col  per column: 1 makes the constant operand itr, 0 makes it imm.
- sel_mux4  in  num_col*4  per column: mux0 = [4c+3:4c+2], mux1 = [4c+1:4c].
- op  in  num_col*2  per-column opcode = [2c+1:2c].
- wen_RF  in  num_col  per-column register-file write enable.
- rd_addr_RF  in  num_col*dwidth_RFadd  per-column read address.
- wr_addr_RF  in  num_col*dwidth_RFadd  per-column write address.
- stream_out_PEa0  out  phit_size  column 0 (A0) registered result.
- stream_out_PEa1  out  phit_size  column 1 (A1) registered result.
- stream_out_PEb  out  phit_size  column 2 (B) registered result.
- stream_out_PEc0  out  phit_size  column 3 (C0) registered result.
- stream_out_PEc1  out  phit_size  column 4 (C1) registered result.
- stream_out  out  phit_size  column 5 (D) registered result; final output.

REQ-002 Parameters SHALL be: phit_size = 512, dwidth_double = 64, num_col = 6, dwidth_RFadd = 4, lanes = 8.

Function
REQ-003 Columns SHALL form a linear pipeline A0→A1→B→C0→C1→D. Column 0 input = stream_in; column c input = registered output of column c-1.
REQ-004 Each column SHALL process all 8 lanes independently and identically. imm/itr SHALL be broadcast to every lane.
REQ-005 mux0 selects operand A and mux1 selects operand B, per lane, with these encodings:
- 00 = column input lane.
- 01 = register-file read-data lane.
- 10 = constant lane (itr if isItr[c] = 1, else imm).
- 11 = the column's own registered output lane (feedback/accumulate).
REQ-006 Opcodes SHALL be 64-bit two's-complement integer operations:
- 00 = A+B.
- 01 = A−B.
- 10 = low 64 bits of A×B.
- 11 = pass A.
All results wrap modulo 2^64, with no flags.
REQ-007 Each column result SHALL be registered every cycle, with no enable and no handshake. Latency is 1 cycle per column; stream_in to stream_out is 6 cycles.
REQ-008 Each column SHALL own a 16-entry × 512-bit register file:
- Read is combinational from rd_addr_RF.
- On a clock edge with wen_RF[c] = 1, the column's computed (pre-register) result is written to wr_addr_RF.
REQ-009 Read and write to the same address in the same cycle SHALL return the old contents (no bypass).
REQ-010 Control inputs SHALL take effect combinationally on the next clock edge. Changing sel/op mid-stream affects only data registered from that edge onward.

Reset
REQ-011 While rst = 1, all six output registers and all register-file entries SHALL be 0, independent of clk.
REQ-012 After rst deasserts, operation SHALL resume on the next rising edge. Reset mid-stream discards all in-flight data.

Structure
REQ-013 A shared package SHALL hold:
- phit_size, dwidth_double, num_col, dwidth_RFadd, lanes.
- Opcode enum: ADD, SUB, MUL, PASS.
- Mux-select enum: STREAM, RF, CONST, FEEDBACK.
REQ-014 One sub-module "pe_column" SHALL implement a single column (operand muxes, 8 lane ALUs, output register, register file). data_path SHALL instantiate it num_col times and do the slicing and chaining.

Verification
REQ-015 Reset: assert rst with arbitrary inputs -> all outputs 0 immediately. Write RF, reset, read -> 0.
REQ-016 Chain add:
- Stimulus: stream_in lane0 = 3; column 0 mux0 = CONST, mux1 = STREAM, op = ADD, imm = 1; columns 1–5 mux0 = STREAM, op = PASS.
- stream_out_PEa0 lane0 = 4 after 1 cycle; stream_out lane0 = 4 after 6 cycles.
- Lanes 1–7 = 1.
REQ-017 Ops:
- Stimulus: column 2 with A = 7 (STREAM), B = imm 10.
- ADD → 17.
- SUB → 0xFFFF_FFFF_FFFF_FFFD.
- MUL → 70.
- MUL with A = 2^63, B = 2 → 0 (wrap).
REQ-018 isItr: column 3 mux0 = CONST, imm = 5, itr = 9, op = PASS:
- isItr = 0 → 5.
- isItr = 1 → 9 on the next edge.
REQ-019 Feedback accumulate: column 1 mux0 = FEEDBACK, mux1 = CONST, imm = 1, ADD, from reset -> output 1, 2, 3, … on successive cycles.
REQ-020 RF:
- Write column 4 result 42 at address 3 with wen_RF = 1.
- Later read address 3 via mux0 = RF, PASS → 42.
- Same-cycle read/write of address 5 returns the prior value.
